spi_arbiter: RTL
================

// Module: spi_arbiter
// PURPOSE
// - Shares one SPI byte engine (ports ce/tx/rx/d/q) between two requesters: 0 = divMMC port logic, 1 = loader.
// - Sequences engine starts, counts transfer length, round-robins, honours per-requester lock (multi-byte CS hold).
// - Drives one active-low chip select per requester.
// - Keeps each requester's pipelined read semantics: its q is the result of its own previous transfer.
// PARAMETERS
// - TICKS  16  engine ce ticks per byte after the start tick (8 bits x 2 clock phases)
// PORTS
// - clock      in   1   system clock; only clock, all logic on posedge
// - reset      in   1   asynchronous, active-high
// - ce         in   1   engine tick enable, same signal fed to the engine
// - req_tx     in   2   per-requester write strobe, 1 clock, sends req_d
// - req_rx     in   2   per-requester read strobe, 1 clock, sends 8'hFF
// - req_d      in   16  tx byte; requester i in [8*i+:8], sampled with the strobe
// - req_lock   in   2   hold grant (and cs_n low) between bytes while high
// - req_busy   out  2   strobe accepted, transfer not yet complete
// - req_done   out  2   1-clock pulse on the tick the requester's transfer ends
// - req_q      out  16  per-requester read byte, [8*i+:8]
// - cs_n       out  2   chip selects, low while owned
// - spi_tx     out  1   to engine tx
// - spi_rx     out  1   to engine rx
// - spi_d      out  8   to engine d
// - spi_q      in   8   from engine q (updates on the ce tick of each start)
// BEHAVIOUR
// - Reset: FSM=IDLE, spi_tx/spi_rx=0, spi_d=0, cs_n=2'b11, req_busy=0, req_done=0, req_q=0, rr=0, last=0, count=0.
// - Strobe capture: req_tx|req_rx while req_busy[i]=0 sets pend[i], kind, data; req_busy[i]=1 next clock.
//   Strobes while busy are ignored. tx and rx together: tx wins.
// - IDLE: pick owner from pend. If owner locked and lock still high, only that owner; else round robin,
//   rr starts favouring 0; rr flips to the other requester after each grant. -> START same clock as pick.
// - START: drive spi_tx or spi_rx level plus spi_d = owner data; cs_n[owner]=0.
//   On first clock with ce=1, the engine starts and the FSM -> SHIFT with count=0.
//   Drop spi_tx/spi_rx that same clock.
// - Result routing: one clock after the start tick, copy spi_q into req_q[last]; then last <= owner.
//   A requester therefore sees its previous byte, the same as owning the engine alone.
// - SHIFT: count++ per ce. At count==TICKS-1 with ce: pulse req_done[owner], clear pend/busy, -> IDLE.
//   Next start is no earlier than the following ce tick (17 ce ticks per byte minimum).
// - Lock: cs_n[owner] remains 0 in IDLE while req_lock[owner]=1. The other requester is not granted.
//   Lock dropped in IDLE: cs_n goes high next clock, ownership released.
// - Lock asserted by a non-owner: no effect until that requester is granted.
// - cs_n: at most one bit low at any time. Owner change always passes one clock with cs_n=2'b11.
// - Simultaneous strobes from both requesters in IDLE: rr decides; the loser stays busy and is served next.
// - Lock drop mid-transfer: the byte completes, then ownership is released.
// - Reset mid-transfer: all outputs return to reset values immediately; the engine is resynchronised by its own counter.
// - ce held low: the FSM stalls in START/SHIFT; no timeout.
// STRUCTURE
// - Shared package zx_spi_pkg: FSM state encoding (IDLE, START, SHIFT), SPI_TICKS=16, SPI_FILL=8'hFF.
// - One sub-module, rr_pick2: 2-way round-robin pick (inputs pend, rr, lock_owner; outputs grant, valid).
// - Engine instantiated by the parent, not inside this block.
// TESTING
// - Reset then single req_tx[0], d=8'hA5, ce every 2nd clock:
//   spi_tx pulses once, cs_n=2'b10, req_done[0] after 16 ce ticks, busy drops.
// - Pipelined read: req_rx[0] twice with miso pattern 8'h3C on the first byte.
//   req_q[0]=8'h3C one clock after the second start tick.
// - Same-clock strobes req_tx=2'b11 after reset: requester 0 served first, then 1.
//   cs_n shows 2'b10, 2'b11, 2'b01, never 2'b00.
// - req_lock[1]=1 across 3 bytes while requester 0 strobes:
//   requester 0 stays busy until lock[1] drops, then is granted; cs_n[1] low throughout.
// - Interleaved reads A (req 0), B (req 1), A: req_q[0] gets A1 at B's start, req_q[1] gets B at A2's start.
// - Assert reset at count=7 of a transfer: cs_n=2'b11, busy=0, spi_tx=0 immediately.
//   A fresh request afterwards completes normally.

Source files
------------

// File: rtl/zx_spi_pkg.sv
// Shared definitions for the SPI engine arbiter: FSM encoding, byte timing and the
// fill byte sent on read-only transfers.
package zx_spi_pkg;

  localparam int         SPI_TICKS = 16;
  localparam logic [7:0] SPI_FILL  = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT
  } spi_state_e;

endpackage

// File: rtl/spi_arbiter_if.sv
// Requester and engine signals of the SPI arbiter. The slave modport is the arbiter;
// the master modport drives requests and the engine's q (parent / bench side).
interface spi_arbiter_if;

  logic        ce;
  logic [1:0]  req_tx;
  logic [1:0]  req_rx;
  logic [15:0] req_d;
  logic [1:0]  req_lock;
  logic [1:0]  req_busy;
  logic [1:0]  req_done;
  logic [15:0] req_q;
  logic [1:0]  cs_n;
  logic        spi_tx;
  logic        spi_rx;
  logic [7:0]  spi_d;
  logic [7:0]  spi_q;

  modport slave (
    input  ce, req_tx, req_rx, req_d, req_lock, spi_q,
    output req_busy, req_done, req_q, cs_n, spi_tx, spi_rx, spi_d
  );

  modport master (
    output ce, req_tx, req_rx, req_d, req_lock, spi_q,
    input  req_busy, req_done, req_q, cs_n, spi_tx, spi_rx, spi_d
  );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick. A non-zero one-hot lock_owner restricts the pick to
// that requester; otherwise the requester named by rr is favoured.
module rr_pick2 (
  input  logic [1:0] pend,
  input  logic       rr,
  input  logic [1:0] lock_owner,
  output logic       grant,
  output logic       valid
);

  // NOTE: every output gets a default before the branches so no latch is inferred.
  always_comb begin
    grant = rr;
    valid = 1'b0;
    if (lock_owner != 2'b00) begin
      grant = lock_owner[1];
      valid = |(pend & lock_owner);
    end else if (pend[rr]) begin
      grant = rr;
      valid = 1'b1;
    end else if (pend[~rr]) begin
      grant = ~rr;
      valid = 1'b1;
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI byte engine between the divMMC port logic (0) and the loader (1):
// captures strobes, sequences engine starts, honours locks and routes pipelined reads.
module spi_arbiter
  import zx_spi_pkg::*;
#(
  parameter int TICKS = SPI_TICKS
) (
  input  logic          clock,
  input  logic          reset,
  spi_arbiter_if.slave  bus
);

  localparam int CW = $clog2(TICKS);

  spi_state_e       state_q, state_d;
  logic             owner_q, owner_d;
  logic             owned_q, owned_d;
  logic             rr_q, rr_d;
  logic             last_q, last_d;
  logic             route_q, route_d;
  logic [CW-1:0]    count_q, count_d;
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       kind_q, kind_d;
  logic [1:0][7:0]  data_q, data_d;
  logic [1:0]       done_q, done_d;
  logic [1:0][7:0]  rdata_q, rdata_d;

  logic [1:0]       lock_mask;
  logic             pick_grant;
  logic             pick_valid;

  // Only the current owner's lock counts; a lock from anyone else waits for a grant.
  assign lock_mask = (owned_q && bus.req_lock[owner_q]) ? (2'b01 << owner_q) : 2'b00;

  rr_pick2 u_pick (
    .pend       (pend_q),
    .rr         (rr_q),
    .lock_owner (lock_mask),
    .grant      (pick_grant),
    .valid      (pick_valid)
  );

  // NOTE: combinational logic uses blocking '=', the state register below uses '<='.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    owned_d = owned_q;
    rr_d    = rr_q;
    last_d  = last_q;
    route_d = 1'b0;
    count_d = count_q;
    pend_d  = pend_q;
    kind_d  = kind_q;
    data_d  = data_q;
    done_d  = 2'b00;
    rdata_d = rdata_q;

    for (int i = 0; i < 2; i++) begin
      if (!pend_q[i] && (bus.req_tx[i] || bus.req_rx[i])) begin
        pend_d[i] = 1'b1;
        kind_d[i] = bus.req_tx[i];
        data_d[i] = bus.req_d[8*i +: 8];
      end
    end

    // The engine's q now holds the byte of the previous transfer, whoever issued it.
    if (route_q) begin
      rdata_d[last_q] = bus.spi_q;
      last_d          = owner_q;
    end

    case (state_q)
      IDLE: begin
        if (owned_q && !bus.req_lock[owner_q]) begin
          owned_d = 1'b0;
        end else if (pick_valid) begin
          owner_d = pick_grant;
          owned_d = 1'b1;
          rr_d    = ~pick_grant;
          state_d = START;
        end
      end
      START: begin
        if (bus.ce) begin
          state_d = SHIFT;
          count_d = '0;
          route_d = 1'b1;
        end
      end
      SHIFT: begin
        if (bus.ce) begin
          if (count_q == CW'(TICKS - 1)) begin
            done_d[owner_q] = 1'b1;
            pend_d[owner_q] = 1'b0;
            owned_d         = bus.req_lock[owner_q];
            state_d         = IDLE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the small data/result registers are reset too, so spi_d and req_q are defined from reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      owned_q <= 1'b0;
      rr_q    <= 1'b0;
      last_q  <= 1'b0;
      route_q <= 1'b0;
      count_q <= '0;
      pend_q  <= 2'b00;
      kind_q  <= 2'b00;
      data_q  <= '0;
      done_q  <= 2'b00;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      owned_q <= owned_d;
      rr_q    <= rr_d;
      last_q  <= last_d;
      route_q <= route_d;
      count_q <= count_d;
      pend_q  <= pend_d;
      kind_q  <= kind_d;
      data_q  <= data_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  // Start levels are held through START and vanish on the tick the engine takes them.
  assign bus.spi_tx   = (state_q == START) &&  kind_q[owner_q];
  assign bus.spi_rx   = (state_q == START) && !kind_q[owner_q];
  assign bus.spi_d    = (state_q != START) ? 8'h00
                      : (kind_q[owner_q] ? data_q[owner_q] : SPI_FILL);
  assign bus.cs_n     = owned_q ? ~(2'b01 << owner_q) : 2'b11;
  assign bus.req_busy = pend_q;
  assign bus.req_done = done_q;
  assign bus.req_q    = rdata_q;

endmodule
